apb_master: RTL and testbench
=============================

APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, APB address width.
REQ-002 SHALL have parameter DATA_W, default 32, APB data width.
REQ-003 SHALL have parameter TIMEOUT, default 16, maximum ACCESS wait cycles; 0 disables the timeout.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 cmd_valid  input  1  command request.
REQ-007 cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-008 cmd_write  input  1  1=write, 0=read.
REQ-009 cmd_addr  input  ADDR_W  byte address.
REQ-010 cmd_wdata  input  DATA_W  write data.
REQ-011 PSEL  output  1  APB select.
REQ-012 PENABLE  output  1  APB enable.
REQ-013 PADDR  output  ADDR_W  APB address.
REQ-014 PWRITE  output  1  APB direction.
REQ-015 PWDATA  output  DATA_W  APB write data.
REQ-016 PREADY  input  1  slave ready.
REQ-017 PRDATA  input  DATA_W  slave read data.
REQ-018 PSLVERR  input  1  slave error.
REQ-019 rsp_valid  output  1  one-cycle response pulse.
REQ-020 rsp_rdata  output  DATA_W  read data; 0 for writes and errors.
REQ-021 rsp_err  output  1  transfer failed (PSLVERR, misalignment or timeout).
REQ-022 rsp_timeout  output  1  failure was a timeout.

Function
REQ-023 SHALL implement FSM states IDLE, SETUP, ACCESS; all outputs registered.
REQ-024 IDLE: cmd_ready=1, PSEL=0, PENABLE=0; in every other state cmd_ready=0.
REQ-025 When cmd_valid&cmd_ready and cmd_addr[1:0]==0, the block SHALL latch addr/write/wdata into PADDR/PWRITE/PWDATA and enter SETUP next cycle (PSEL=1, PENABLE=0).
REQ-026 When cmd_valid&cmd_ready and cmd_addr[1:0]!=0, the block SHALL start no bus transfer, stay in IDLE and assert rsp_valid=1, rsp_err=1, rsp_timeout=0, rsp_rdata=0 the next cycle.
REQ-027 SETUP SHALL last exactly one cycle, then ACCESS (PSEL=1, PENABLE=1).
REQ-028 PADDR, PWRITE, PWDATA SHALL be stable from SETUP through the last ACCESS cycle and hold their last values in IDLE.
REQ-029 In ACCESS with PREADY=1, the block SHALL return to IDLE next cycle and pulse rsp_valid with rsp_err=PSLVERR, rsp_timeout=0, rsp_rdata=PRDATA for error-free reads and 0 otherwise.
REQ-030 In ACCESS with PREADY=0, the block SHALL hold ACCESS and increment a wait counter of width $clog2(TIMEOUT+1), cleared on entry to SETUP.
REQ-031 With TIMEOUT>0, when the wait counter reaches TIMEOUT and PREADY=0, the block SHALL drop PSEL/PENABLE, return to IDLE and pulse rsp_valid, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-032 PREADY=1 in the cycle the counter reaches TIMEOUT SHALL count as normal completion (REQ-029).
REQ-033 Minimum transfer latency: accept->rsp_valid = 3 cycles (SETUP, ACCESS, response); one IDLE cycle SHALL separate consecutive transfers.
REQ-034 PREADY, PRDATA, PSLVERR SHALL be ignored outside ACCESS.

Reset
REQ-035 On rst=1, the block SHALL immediately force IDLE, cmd_ready=0 while rst high, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, counter=0.
REQ-036 Reset during SETUP/ACCESS SHALL abort the transfer with no rsp_valid; cmd_ready=1 the first cycle after rst deasserts.

Verification
REQ-037 Write 0x0000_0010 data 0xDEAD_BEEF, PREADY=1 immediately -> PSEL 2 cycles, PENABLE 1 cycle, rsp_valid at cycle 3, rsp_err=0, rsp_rdata=0.
REQ-038 Read 0x0000_0020, PREADY low 4 cycles then high with PRDATA=0x1234_5678 -> PADDR stable 6 cycles, rsp_rdata=0x1234_5678, rsp_err=0.
REQ-039 Read with PSLVERR=1 at PREADY -> rsp_err=1, rsp_timeout=0, rsp_rdata=0.
REQ-040 TIMEOUT=16, PREADY held 0 -> abort after 16 wait cycles, rsp_err=1, rsp_timeout=1, PSEL=0 next cycle; repeat with PREADY=1 on cycle 16 -> normal completion.
REQ-041 cmd_addr=0x0000_0003 -> no PSEL, rsp_valid next cycle with rsp_err=1.
REQ-042 rst pulsed during ACCESS -> PSEL/PENABLE low asynchronously, no rsp_valid, new command accepted after release.

Source files
------------

// File: rtl/apb_master.sv
// APB master: turns single-beat commands into APB SETUP/ACCESS transfers,
// rejects misaligned addresses locally and aborts slaves that never answer.
module apb_master #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              PSEL,
   output logic              PENABLE,
   output logic [ADDR_W-1:0] PADDR,
   output logic              PWRITE,
   output logic [DATA_W-1:0] PWDATA,
   input  logic              PREADY,
   input  logic [DATA_W-1:0] PRDATA,
   input  logic              PSLVERR,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              rsp_timeout
);

   // Counter is kept at least one bit wide so TIMEOUT=0 still elaborates.
   localparam int               CNT_W       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam bit               TIMEOUT_EN  = (TIMEOUT > 0);
   localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
   localparam logic [DATA_W-1:0] DATA_ZERO  = {DATA_W{1'b0}};
   localparam logic [ADDR_W-1:0] ADDR_ZERO  = {ADDR_W{1'b0}};

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_ACCESS = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [CNT_W-1:0]  r_wait_cnt;
   logic [CNT_W-1:0]  w_wait_cnt_nxt;

   logic              r_cmd_ready,   w_cmd_ready_nxt;
   logic              r_psel,        w_psel_nxt;
   logic              r_penable,     w_penable_nxt;
   logic [ADDR_W-1:0] r_paddr,       w_paddr_nxt;
   logic              r_pwrite,      w_pwrite_nxt;
   logic [DATA_W-1:0] r_pwdata,      w_pwdata_nxt;
   logic              r_rsp_valid,   w_rsp_valid_nxt;
   logic [DATA_W-1:0] r_rsp_rdata,   w_rsp_rdata_nxt;
   logic              r_rsp_err,     w_rsp_err_nxt;
   logic              r_rsp_timeout, w_rsp_timeout_nxt;

   logic              w_accept;
   logic              w_aligned;
   logic              w_timeout_hit;

   // cmd_ready is only high in IDLE, so this is also the IDLE-state handshake.
   assign w_accept      = cmd_valid & r_cmd_ready;
   assign w_aligned     = (cmd_addr[1:0] == 2'b00);
   assign w_timeout_hit = TIMEOUT_EN && (r_wait_cnt == TIMEOUT_CNT);

   // State register plus all registered outputs; reset aborts any transfer silently.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_wait_cnt    <= CNT_ZERO;
         r_cmd_ready   <= 1'b0;
         r_psel        <= 1'b0;
         r_penable     <= 1'b0;
         r_paddr       <= ADDR_ZERO;
         r_pwrite      <= 1'b0;
         r_pwdata      <= DATA_ZERO;
         r_rsp_valid   <= 1'b0;
         r_rsp_rdata   <= DATA_ZERO;
         r_rsp_err     <= 1'b0;
         r_rsp_timeout <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_wait_cnt    <= w_wait_cnt_nxt;
         r_cmd_ready   <= w_cmd_ready_nxt;
         r_psel        <= w_psel_nxt;
         r_penable     <= w_penable_nxt;
         r_paddr       <= w_paddr_nxt;
         r_pwrite      <= w_pwrite_nxt;
         r_pwdata      <= w_pwdata_nxt;
         r_rsp_valid   <= w_rsp_valid_nxt;
         r_rsp_rdata   <= w_rsp_rdata_nxt;
         r_rsp_err     <= w_rsp_err_nxt;
         r_rsp_timeout <= w_rsp_timeout_nxt;
      end
   end

   // Next-state selection: IDLE -> SETUP -> ACCESS -> IDLE on ready or timeout.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept && w_aligned) begin
               w_state_nxt = S_SETUP;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_SETUP: begin
            w_state_nxt = S_ACCESS;
         end
         S_ACCESS: begin
            if (PREADY || w_timeout_hit) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = S_ACCESS;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Next values of the registered outputs, derived from current state and inputs.
   always_comb begin
      w_cmd_ready_nxt   = (w_state_nxt == S_IDLE);
      w_psel_nxt        = (w_state_nxt != S_IDLE);
      w_penable_nxt     = (w_state_nxt == S_ACCESS);
      w_paddr_nxt       = r_paddr;
      w_pwrite_nxt      = r_pwrite;
      w_pwdata_nxt      = r_pwdata;
      w_wait_cnt_nxt    = r_wait_cnt;
      w_rsp_valid_nxt   = 1'b0;
      w_rsp_rdata_nxt   = DATA_ZERO;
      w_rsp_err_nxt     = 1'b0;
      w_rsp_timeout_nxt = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept && w_aligned) begin
               w_paddr_nxt    = cmd_addr;
               w_pwrite_nxt   = cmd_write;
               w_pwdata_nxt   = cmd_wdata;
               w_wait_cnt_nxt = CNT_ZERO;
            end else if (w_accept) begin
               // Misaligned: answered locally, nothing goes on the bus.
               w_rsp_valid_nxt = 1'b1;
               w_rsp_err_nxt   = 1'b1;
            end else begin
               w_wait_cnt_nxt = r_wait_cnt;
            end
         end
         S_SETUP: begin
            w_wait_cnt_nxt = r_wait_cnt;
         end
         S_ACCESS: begin
            if (PREADY) begin
               w_rsp_valid_nxt = 1'b1;
               w_rsp_err_nxt   = PSLVERR;
               if (!r_pwrite && !PSLVERR) begin
                  w_rsp_rdata_nxt = PRDATA;
               end else begin
                  w_rsp_rdata_nxt = DATA_ZERO;
               end
            end else if (w_timeout_hit) begin
               w_rsp_valid_nxt   = 1'b1;
               w_rsp_err_nxt     = 1'b1;
               w_rsp_timeout_nxt = 1'b1;
            end else begin
               w_wait_cnt_nxt = r_wait_cnt + CNT_ONE;
            end
         end
         default: begin
            w_wait_cnt_nxt = CNT_ZERO;
         end
      endcase
   end

   assign cmd_ready   = r_cmd_ready;
   assign PSEL        = r_psel;
   assign PENABLE     = r_penable;
   assign PADDR       = r_paddr;
   assign PWRITE      = r_pwrite;
   assign PWDATA      = r_pwdata;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_rdata   = r_rsp_rdata;
   assign rsp_err     = r_rsp_err;
   assign rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_apb_master.sv
// Directed plus randomized bench for apb_master with a transaction-level model.
module tb_apb_master;

   localparam int TMO = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_write = 1'b0;
   logic [31:0] cmd_addr = 32'h0;
   logic [31:0] cmd_wdata = 32'h0;
   logic        PSEL;
   logic        PENABLE;
   logic [31:0] PADDR;
   logic        PWRITE;
   logic [31:0] PWDATA;
   logic        PREADY = 1'b0;
   logic [31:0] PRDATA = 32'h0;
   logic        PSLVERR = 1'b0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        rsp_timeout;

   int checks   = 0;
   int failures = 0;

   logic [31:0] last_paddr  = 32'h0;
   logic        last_pwrite = 1'b0;
   logic [31:0] last_pwdata = 32'h0;

   apb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA),
      .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout)
   );

   always #5 clk = ~clk;

   // Expected outcome of one command, from the protocol rules alone.
   typedef struct packed {
      logic        misaligned;
      int          n_access;
      logic        err;
      logic        tmo;
      logic [31:0] rdata;
   } exp_t;

   function automatic exp_t model(input logic wr, input logic [31:0] addr, input int waits,
                                  input logic slverr, input logic [31:0] rd);
      exp_t m;
      m.misaligned = ((addr % 32'd4) != 32'd0);
      if (m.misaligned) begin
         m.n_access = 0; m.err = 1'b1; m.tmo = 1'b0; m.rdata = 32'h0;
      end else if (TMO > 0 && waits > TMO) begin
         m.n_access = TMO + 1; m.err = 1'b1; m.tmo = 1'b1; m.rdata = 32'h0;
      end else begin
         m.n_access = waits + 1; m.err = slverr; m.tmo = 1'b0;
         m.rdata = (!wr && !slverr) ? rd : 32'h0;
      end
      return m;
   endfunction

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic junk_slave();
      PREADY  = 1'($urandom_range(0, 1));
      PSLVERR = 1'($urandom_range(0, 1));
      PRDATA  = $urandom();
   endtask

   task automatic check_bus(input logic sel, input logic en);
      chk1("psel", PSEL, sel);
      chk1("penable", PENABLE, en);
      chk32("paddr", PADDR, last_paddr);
      chk1("pwrite", PWRITE, last_pwrite);
      chk32("pwdata", PWDATA, last_pwdata);
   endtask

   // One command from acceptance through the response cycle; leaves the bench in that cycle.
   task automatic run_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                           input int waits, input logic slverr, input logic [31:0] rd);
      exp_t e;
      e = model(wr, addr, waits, slverr, rd);
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
      chk1("cmd_ready_idle", cmd_ready, 1'b1);
      step();
      cmd_valid = 1'b0; cmd_addr = $urandom(); cmd_wdata = $urandom();
      cmd_write = 1'($urandom_range(0, 1));
      if (e.misaligned) begin
         chk1("mis_rsp_valid", rsp_valid, 1'b1);
         chk1("mis_rsp_err", rsp_err, 1'b1);
         chk1("mis_rsp_timeout", rsp_timeout, 1'b0);
         chk32("mis_rsp_rdata", rsp_rdata, 32'h0);
         check_bus(1'b0, 1'b0);
         junk_slave();
         step();
         chk1("mis_rsp_pulse", rsp_valid, 1'b0);
         chk1("mis_no_psel", PSEL, 1'b0);
      end else begin
         last_paddr = addr; last_pwrite = wr; last_pwdata = wd;
         check_bus(1'b1, 1'b0);
         chk1("setup_cmd_ready", cmd_ready, 1'b0);
         chk1("setup_rsp_valid", rsp_valid, 1'b0);
         junk_slave();
         step();
         for (int k = 0; k < e.n_access; k++) begin
            check_bus(1'b1, 1'b1);
            chk1("access_rsp_valid", rsp_valid, 1'b0);
            if (k == waits) begin
               PREADY = 1'b1; PSLVERR = slverr; PRDATA = rd;
            end else begin
               PREADY = 1'b0; PSLVERR = 1'($urandom_range(0, 1)); PRDATA = $urandom();
            end
            step();
         end
         chk1("rsp_valid", rsp_valid, 1'b1);
         chk1("rsp_err", rsp_err, e.err);
         chk1("rsp_timeout", rsp_timeout, e.tmo);
         chk32("rsp_rdata", rsp_rdata, e.rdata);
         chk1("rsp_cmd_ready", cmd_ready, 1'b1);
         check_bus(1'b0, 1'b0);
         junk_slave();
      end
   endtask

   // Safety net so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      logic        wr;
      int          sel;
      int          w;

      // Reset values, asserted asynchronously away from any clock edge.
      #2 rst = 1'b1;
      #1;
      chk1("rst_psel", PSEL, 1'b0);
      chk1("rst_penable", PENABLE, 1'b0);
      chk1("rst_cmd_ready", cmd_ready, 1'b0);
      chk32("rst_paddr", PADDR, 32'h0);
      chk32("rst_pwdata", PWDATA, 32'h0);
      chk1("rst_pwrite", PWRITE, 1'b0);
      chk1("rst_rsp_valid", rsp_valid, 1'b0);
      chk32("rst_rsp_rdata", rsp_rdata, 32'h0);
      chk1("rst_rsp_err", rsp_err, 1'b0);
      chk1("rst_rsp_timeout", rsp_timeout, 1'b0);
      step(); step();
      chk1("rst_hold_cmd_ready", cmd_ready, 1'b0);
      #2 rst = 1'b0;
      step();
      chk1("post_rst_cmd_ready", cmd_ready, 1'b1);

      // Write with immediate ready.
      run_xfer(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 1'b0, 32'hFFFF_FFFF);
      // Read with four wait cycles.
      run_xfer(1'b0, 32'h0000_0020, 32'h0000_0000, 4, 1'b0, 32'h1234_5678);
      // Read with slave error.
      run_xfer(1'b0, 32'h0000_0024, 32'h0000_0000, 1, 1'b1, 32'hCAFE_F00D);
      // Slave never ready: timeout.
      run_xfer(1'b0, 32'h0000_0028, 32'h0000_0000, 1000, 1'b0, 32'h5555_AAAA);
      // Ready in the cycle the counter hits the limit: normal completion.
      run_xfer(1'b0, 32'h0000_002C, 32'h0000_0000, TMO, 1'b0, 32'hA5A5_0001);
      // Write with slave error.
      run_xfer(1'b1, 32'h0000_0030, 32'h0BAD_0BAD, 2, 1'b1, 32'h7777_7777);
      // Misaligned commands, then an aligned one right behind.
      run_xfer(1'b0, 32'h0000_0003, 32'h0000_0000, 0, 1'b0, 32'h0);
      run_xfer(1'b1, 32'h0000_0102, 32'h1111_2222, 0, 1'b0, 32'h0);
      run_xfer(1'b0, 32'h0000_0104, 32'h0000_0000, 0, 1'b0, 32'h8765_4321);

      // Randomized mix.
      for (int n = 0; n < 30; n++) begin
         a   = $urandom();
         wr  = 1'($urandom_range(0, 1));
         sel = int'($urandom_range(0, 7));
         if (sel != 0) begin
            a[1:0] = 2'b00;
         end
         w = int'($urandom_range(0, 5));
         if (sel == 7) begin
            w = int'($urandom_range(TMO - 2, TMO + 3));
         end
         run_xfer(wr, a, $urandom(), w, 1'($urandom_range(0, 1)), $urandom());
      end

      // Reset during ACCESS: silent abort, then normal operation.
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0040; cmd_wdata = 32'h0;
      step();
      cmd_valid = 1'b0; PREADY = 1'b0;
      step();
      step();
      chk1("pre_rst_penable", PENABLE, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk1("arst_psel", PSEL, 1'b0);
      chk1("arst_penable", PENABLE, 1'b0);
      chk1("arst_rsp_valid", rsp_valid, 1'b0);
      chk32("arst_paddr", PADDR, 32'h0);
      PREADY = 1'b1;
      step();
      chk1("arst_hold_rsp_valid", rsp_valid, 1'b0);
      chk1("arst_hold_cmd_ready", cmd_ready, 1'b0);
      #2 rst = 1'b0;
      step();
      chk1("arst_rel_cmd_ready", cmd_ready, 1'b1);
      chk1("arst_rel_rsp_valid", rsp_valid, 1'b0);
      last_paddr = 32'h0; last_pwrite = 1'b0; last_pwdata = 32'h0;
      run_xfer(1'b0, 32'h0000_0044, 32'h0, 3, 1'b0, 32'h0F0F_F0F0);
      step();
      chk1("final_rsp_pulse", rsp_valid, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
